// File: rtl/axi_xbar_wrr_arb_if.sv
// Address-arbitration bundle between the crossbar master port and its weighted round-robin arbiter.
// The arbiter connects through the slave modport, and the requesting side connects through the master modport.
interface axi_xbar_wrr_arb_if #(
   parameter int NUM_REQ     = 5,
   parameter int IDX_BITS    = $clog2(NUM_REQ),
   parameter int WEIGHT_BITS = 4
);
   logic [NUM_REQ-1:0]             reqs;
   logic                           accept;
   logic [NUM_REQ*WEIGHT_BITS-1:0] cfg_weights;
   logic                           cfg_load;
   logic                           grant_valid;
   logic [NUM_REQ-1:0]             grant_b;
   logic [IDX_BITS-1:0]            grant_i;
   logic                           reload;

   modport master (
      output reqs, accept, cfg_weights, cfg_load,
      input  grant_valid, grant_b, grant_i, reload
   );

   modport slave (
      input  reqs, accept, cfg_weights, cfg_load,
      output grant_valid, grant_b, grant_i, reload
   );
endinterface

// File: rtl/axi_xbar_wrr_arb.sv
// Weighted round-robin arbiter for the AW/AR address channels of one crossbar master port.
// Define AXI_XBAR_ARB_PRIO0_EN to give requester 0 strict, credit-free priority.
module axi_xbar_wrr_arb #(
   parameter int NUM_REQ     = 5,
   parameter int IDX_BITS    = $clog2(NUM_REQ),
   parameter int WEIGHT_BITS = 4
) (
   input logic                clk,
   input logic                rst,
   axi_xbar_wrr_arb_if.slave  bus
);

`ifdef AXI_XBAR_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   typedef enum logic {ARB, GRANT} state_e;

   state_e                 state_q, state_d;
   logic [IDX_BITS-1:0]    ptr_q, ptr_d;
   logic                   grant_valid_q, grant_valid_d;
   logic [NUM_REQ-1:0]     grant_b_q, grant_b_d;
   logic [IDX_BITS-1:0]    grant_i_q, grant_i_d;
   logic                   reload_q, reload_d;
   logic [WEIGHT_BITS-1:0] weight_q [NUM_REQ];
   logic [WEIGHT_BITS-1:0] weight_d [NUM_REQ];
   logic [WEIGHT_BITS-1:0] credit_q [NUM_REQ];
   logic [WEIGHT_BITS-1:0] credit_d [NUM_REQ];

   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     cand;
   logic                   found;
   logic [IDX_BITS-1:0]    pick;
   logic [IDX_BITS-1:0]    nxt;
   logic [WEIGHT_BITS-1:0] dec;
   logic [WEIGHT_BITS-1:0] wcfg;

   // NOTE: every signal written below gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_valid_d = grant_valid_q;
      grant_b_d     = grant_b_q;
      grant_i_d     = grant_i_q;
      reload_d      = 1'b0;
      weight_d      = weight_q;
      credit_d      = credit_q;
      eligible      = '0;
      cand          = '0;
      found         = 1'b0;
      pick          = ptr_q;
      dec           = '0;
      wcfg          = '0;
      nxt           = (grant_i_q == IDX_BITS'(NUM_REQ-1)) ? '0 : grant_i_q + IDX_BITS'(1);

      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.reqs[i] && (credit_q[i] != '0);
      end

      case (state_q)
         ARB: begin
            if (bus.reqs != '0) begin
               cand = eligible;
               // Every active requester is out of credit, so a new round starts in this same cycle.
               if (eligible == '0 && !(PRIO0 && bus.reqs[0])) begin
                  for (int i = 0; i < NUM_REQ; i++) begin
                     credit_d[i] = weight_q[i];
                  end
                  reload_d = 1'b1;
                  cand     = bus.reqs;
               end
               for (int k = 0; k < NUM_REQ; k++) begin
                  int j;
                  j = int'(ptr_q) + k;
                  if (j >= NUM_REQ) j = j - NUM_REQ;
                  if (!found && cand[j]) begin
                     found = 1'b1;
                     pick  = IDX_BITS'(j);
                  end
               end
               if (PRIO0 && bus.reqs[0]) pick = '0;
               grant_i_d       = pick;
               grant_b_d       = '0;
               grant_b_d[pick] = 1'b1;
               grant_valid_d   = 1'b1;
               state_d         = GRANT;
            end
         end
         GRANT: begin
            if (bus.accept) begin
               if (!(PRIO0 && grant_i_q == '0)) begin
                  dec = credit_q[grant_i_q];
                  if (dec != '0) dec = dec - WEIGHT_BITS'(1);
                  credit_d[grant_i_q] = dec;
                  // Stay on the requester while it has credit, so it gets its grants back to back.
                  ptr_d = (dec == '0) ? nxt : grant_i_q;
               end
               grant_valid_d = 1'b0;
               grant_b_d     = '0;
               state_d       = ARB;
            end else if (!bus.reqs[grant_i_q]) begin
               grant_valid_d = 1'b0;
               grant_b_d     = '0;
               state_d       = ARB;
            end
         end
         default: state_d = ARB;
      endcase

      // Loading the weights runs after the decrement, so the freshly loaded credits win.
      if (bus.cfg_load) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wcfg        = bus.cfg_weights[i*WEIGHT_BITS +: WEIGHT_BITS];
            weight_d[i] = (wcfg == '0) ? WEIGHT_BITS'(1) : wcfg;
            credit_d[i] = weight_d[i];
         end
      end
   end

   // NOTE: the weight and credit arrays are reset like plain flops. They are small register files that must start at weight 1, not RAMs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ARB;
         ptr_q         <= '0;
         grant_valid_q <= 1'b0;
         grant_b_q     <= '0;
         grant_i_q     <= '0;
         reload_q      <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            weight_q[i] <= WEIGHT_BITS'(1);
            credit_q[i] <= WEIGHT_BITS'(1);
         end
      end else begin
         // NOTE: non-blocking assignments make every flop update from the pre-edge values together.
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_b_q     <= grant_b_d;
         grant_i_q     <= grant_i_d;
         reload_q      <= reload_d;
         weight_q      <= weight_d;
         credit_q      <= credit_d;
      end
   end

   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_b     = grant_b_q;
   assign bus.grant_i     = grant_i_q;
   assign bus.reload      = reload_q;

endmodule

// File: tb/tb_axi_xbar_wrr_arb.sv
// Scoreboard bench for axi_xbar_wrr_arb: directed stimulus pushes expected grants, and a monitor checks each new grant.
// The last scenario's expectations follow AXI_XBAR_ARB_PRIO0_EN, the same as the design.
module tb_axi_xbar_wrr_arb;
   localparam int N  = 5;
   localparam int IB = 3;
   localparam int WB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi_xbar_wrr_arb_if #(.NUM_REQ(N), .IDX_BITS(IB), .WEIGHT_BITS(WB)) bus ();

   axi_xbar_wrr_arb #(.NUM_REQ(N), .IDX_BITS(IB), .WEIGHT_BITS(WB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [IB-1:0] idx;
      logic          rl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   bit   prev_gv     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int idx, input bit rl);
      exp_t e;
      e.idx = IB'(idx);
      e.rl  = rl;
      exp_q.push_back(e);
   endtask

   // Checks each new grant (rising grant_valid) against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prev_gv = 1'b0;
      end else begin
         if (bus.grant_valid && !prev_gv) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_grant: got idx %0d, expected no grant at %0t", bus.grant_i, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("grant_i", 32'(bus.grant_i), 32'(mon_e.idx));
               check("grant_b", 32'(bus.grant_b), 32'(1) << mon_e.idx);
               check("reload", 32'(bus.reload), 32'(mon_e.rl));
            end
         end else if (!bus.grant_valid) begin
            check("idle_grant_b", 32'(bus.grant_b), 32'(0));
         end
         prev_gv = bus.grant_valid;
      end
   end

   task automatic wait_grant();
      int t = 0;
      while (!bus.grant_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!bus.grant_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL grant_timeout: got grant_valid=0, expected 1 within 40 cycles at %0t", $time);
      end
   endtask

   // Accepts n grants, one accept pulse per grant; returns at the negedge of the ARB bubble after the last one.
   task automatic serve(input int n);
      for (int i = 0; i < n; i++) begin
         wait_grant();
         bus.accept = 1'b1;
         @(negedge clk);
         bus.accept = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      bus.reqs        = '0;
      bus.accept      = 1'b0;
      bus.cfg_load    = 1'b0;
      bus.cfg_weights = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_weights(input logic [N*WB-1:0] w);
      bus.cfg_weights = w;
      bus.cfg_load    = 1'b1;
      @(negedge clk);
      bus.cfg_load    = 1'b0;
   endtask

   task automatic finish_test(input string name);
      bus.reqs = '0;
      repeat (3) @(negedge clk);
      check(name, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      bus.reqs        = '0;
      bus.accept      = 1'b0;
      bus.cfg_load    = 1'b0;
      bus.cfg_weights = '0;

      #1 rst = 1'b1;
      #1;
      check("rst_grant_valid", 32'(bus.grant_valid), 32'(0));
      check("rst_grant_b", 32'(bus.grant_b), 32'(0));
      check("rst_grant_i", 32'(bus.grant_i), 32'(0));
      check("rst_reload", 32'(bus.reload), 32'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Async reset while a grant on index 3 is held.
      push(3, 1'b0);
      bus.reqs = 5'b01000;
      wait_grant();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t1_async_grant_valid", 32'(bus.grant_valid), 32'(0));
      check("t1_async_grant_b", 32'(bus.grant_b), 32'(0));
      check("t1_async_grant_i", 32'(bus.grant_i), 32'(0));
      @(negedge clk);
      push(2, 1'b0);
      rst      = 1'b0;
      bus.reqs = 5'b00100;
      @(negedge clk);
      check("t1_latency", 32'(bus.grant_valid), 32'(1));
      serve(1);
      finish_test("t1_queue_empty");

      // Default weights behave as plain round robin.
      do_reset();
      push(1, 1'b0); push(2, 1'b0); push(3, 1'b0); push(4, 1'b0);
      push(1, 1'b1); push(2, 1'b0);
      bus.reqs = 5'b11110;
      serve(6);
      finish_test("t2_queue_empty");

      // w1=3, w2=1 gives three back-to-back grants to requester 1 per round.
      do_reset();
      load_weights({4'd1, 4'd1, 4'd1, 4'd3, 4'd1});
      push(1, 1'b0); push(1, 1'b0); push(1, 1'b0); push(2, 1'b0);
      push(1, 1'b1); push(1, 1'b0); push(1, 1'b0); push(2, 1'b0);
      bus.reqs = 5'b00110;
      serve(8);
      finish_test("t3_queue_empty");

      // A withdrawal consumes no credit and leaves the pointer on requester 3.
      do_reset();
      load_weights({4'd1, 4'd2, 4'd1, 4'd1, 4'd1});
      push(3, 1'b0); push(3, 1'b0); push(3, 1'b0); push(1, 1'b0);
      bus.reqs = 5'b01000;
      serve(1);
      wait_grant();
      @(negedge clk);
      check("t4_held", 32'(bus.grant_valid), 32'(1));
      bus.reqs = 5'b00010;
      @(negedge clk);
      check("t4_withdraw", 32'(bus.grant_valid), 32'(0));
      bus.reqs = 5'b01010;
      serve(2);
      finish_test("t4_queue_empty");

      // accept and cfg_load land in the same cycle, so the new weight w4=2 overrides the decremented credit.
      do_reset();
      push(4, 1'b0); push(4, 1'b0); push(4, 1'b0); push(4, 1'b1);
      bus.reqs = 5'b10000;
      wait_grant();
      bus.accept      = 1'b1;
      bus.cfg_weights = {4'd2, 4'd1, 4'd1, 4'd1, 4'd1};
      bus.cfg_load    = 1'b1;
      @(negedge clk);
      bus.accept   = 1'b0;
      bus.cfg_load = 1'b0;
      serve(3);
      finish_test("t5_queue_empty");

      // Requester 0 against requester 1.
      do_reset();
`ifdef AXI_XBAR_ARB_PRIO0_EN
      push(0, 1'b0); push(0, 1'b0); push(0, 1'b0); push(0, 1'b0);
`else
      push(0, 1'b0); push(1, 1'b0); push(0, 1'b1); push(1, 1'b0);
`endif
      bus.reqs = 5'b00011;
      serve(4);
      finish_test("t6_queue_empty");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
